// File: rtl/obj_update_arbiter.sv
// Object position RAM write arbiter.
// Round-robin arbiter that grants RAM write access to one requester at a time.
// Grants are only issued inside the vertical-blanking window. A grant is revoked
// (with an abort pulse) when blanking ends.
// Optional watchdog: define ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYC
// cycles and pulse tmo. Without that macro, tmo is tied to 0.
module obj_update_arbiter #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             vblank,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             abort,
  output logic             tmo,
  output logic [7:0]       frame_grants
);

  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StGrant
  } state_e;

  state_e           r_state;
  logic [N_REQ-1:0] r_grant;
  logic             r_abort;
  logic [7:0]       r_frame_grants;
  logic [IdW-1:0]   r_last_id;
  logic [IdW-1:0]   r_win_id;
  logic             r_vblank_q;

  logic             w_found;
  logic [IdW-1:0]   w_win_id;
  logic [IdW-1:0]   w_cand;
  logic [N_REQ-1:0] w_win_onehot;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_tmo;
  logic       w_expire;

  // Counter holds (cycles granted - 1), so it expires on the last allowed grant cycle.
  assign w_expire = (r_tmo_cnt == 8'(TIMEOUT_CYC - 1));
  assign tmo      = r_tmo;
`else
  assign tmo = 1'b0;
`endif

  assign grant        = r_grant;
  assign abort        = r_abort;
  assign frame_grants = r_frame_grants;

  // Round-robin pick: first active request scanning upward from last_id+1 with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = r_last_id;
    w_cand   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = IdW'((32'(r_last_id) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_win_id = w_cand;
      end
    end
  end

  // One-hot grant vector for the current round-robin winner.
  always_comb begin
    w_win_onehot           = '0;
    w_win_onehot[w_win_id] = 1'b1;
  end

  // Arbiter FSM with registered grant, pulses and per-window grant counter.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_state        <= StIdle;
      r_grant        <= '0;
      r_abort        <= 1'b0;
      r_frame_grants <= 8'd0;
      r_last_id      <= IdW'(N_REQ - 1);
      r_win_id       <= '0;
      r_vblank_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_tmo_cnt      <= 8'd0;
      r_tmo          <= 1'b0;
`endif
    end else begin
      r_abort    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_tmo      <= 1'b0;
`endif
      r_vblank_q <= vblank;

      // New blanking window: restart the per-window grant count.
      if (vblank && !r_vblank_q) begin
        r_frame_grants <= 8'd0;
      end

      unique case (r_state)
        StIdle: begin
          if (vblank && (|req)) begin
            r_state <= StArb;
          end
        end

        StArb: begin
          if (vblank && w_found) begin
            r_state  <= StGrant;
            r_win_id <= w_win_id;
            r_grant  <= w_win_onehot;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt <= 8'd0;
`endif
            if (r_frame_grants != 8'hFF) begin
              r_frame_grants <= r_frame_grants + 8'd1;
            end
          end else begin
            r_state <= StIdle;
          end
        end

        StGrant: begin
          // Priority: end of blanking, then watchdog, then normal release.
          if (!vblank) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_abort   <= 1'b1;
            r_last_id <= r_win_id;
`ifdef ARB_TIMEOUT_EN
          end else if (w_expire) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_tmo     <= 1'b1;
            r_last_id <= r_win_id;
`endif
          end else if (!req[r_win_id]) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_last_id <= r_win_id;
          end else begin
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
          end
        end

        default: begin
          r_state <= StIdle;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
